// File: rtl/tlu_fusion_engine.sv
// -----------------------------------------------------------------------------
// tlu_fusion_engine
//
// Fuses buy/sell votes from NUM_STRAT strategy channels into weighted scores,
// compares them against runtime thresholds and drives a FLAT/LONG/SHORT
// position machine with a post-trade cooldown.
//
// Pipeline: votes are collected into a window that completes once every
// participating strategy has reported. The cycle after completion the scores
// are visible. The cycle after that the decision and any trade pulse appear.
// Windows may complete on consecutive cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   strat_valid/buy/sell/mask   per-strategy vote inputs (NUM_STRAT bits each)
//   buy_weights, sell_weights   packed weights, strategy i at [i*WEIGHT_W +: WEIGHT_W]
//   buy_thresh, sell_thresh     score thresholds; 0 disables that side
//   cooldown_cycles             cycles to suppress trading after a position change
//   buy_signal, sell_signal     single-cycle trade pulses
//   position                    00 FLAT, 01 LONG, 10 SHORT
//   decision_valid              pulses once per evaluated window
//   buy_score, sell_score       last registered scores
//   overrun                     sticky: a strategy reported twice in one window
//
// Build option: define TLU_FLIP_EN to reverse LONG<->SHORT directly on an
// opposing signal instead of returning to FLAT.
// -----------------------------------------------------------------------------
module tlu_fusion_engine #(
  parameter int NUM_STRAT  = 3,
  parameter int WEIGHT_W   = 4,
  parameter int SCORE_W    = 8,
  parameter int COOLDOWN_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_STRAT-1:0]          strat_valid,
  input  logic [NUM_STRAT-1:0]          strat_buy,
  input  logic [NUM_STRAT-1:0]          strat_sell,
  input  logic [NUM_STRAT-1:0]          strat_mask,
  input  logic [NUM_STRAT*WEIGHT_W-1:0] buy_weights,
  input  logic [NUM_STRAT*WEIGHT_W-1:0] sell_weights,
  input  logic [SCORE_W-1:0]            buy_thresh,
  input  logic [SCORE_W-1:0]            sell_thresh,
  input  logic [COOLDOWN_W-1:0]         cooldown_cycles,
  output logic                          buy_signal,
  output logic                          sell_signal,
  output logic [1:0]                    position,
  output logic                          decision_valid,
  output logic [SCORE_W-1:0]            buy_score,
  output logic [SCORE_W-1:0]            sell_score,
  output logic                          overrun
);

  typedef enum logic [1:0] {
    POS_FLAT  = 2'b00,
    POS_LONG  = 2'b01,
    POS_SHORT = 2'b10
  } pos_e;

  // One spare bit lets a running sum overflow SCORE_W before saturation.
  localparam int                ACC_W     = SCORE_W + 1;
  localparam logic [ACC_W-1:0]  SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  logic [NUM_STRAT-1:0]  cap_buy_q, cap_buy_d;
  logic [NUM_STRAT-1:0]  cap_sell_q, cap_sell_d;
  logic [NUM_STRAT-1:0]  got_q, got_d;
  logic                  overrun_q, overrun_d;
  logic                  score_vld_q, score_vld_d;
  logic [SCORE_W-1:0]    buy_score_q, buy_score_d;
  logic [SCORE_W-1:0]    sell_score_q, sell_score_d;
  pos_e                  pos_q, pos_d;
  logic [COOLDOWN_W-1:0] cool_q, cool_d;
  logic                  dec_vld_q, dec_vld_d;
  logic                  buy_sig_q, buy_sig_d;
  logic                  sell_sig_q, sell_sig_d;

  logic [NUM_STRAT-1:0]  arrive;
  logic                  window_done;
  logic [ACC_W-1:0]      buy_acc, sell_acc;
  logic                  raw_buy, raw_sell;

  // Collection and score stage. Scores are summed from this cycle's captures
  // (including same-cycle arrivals) so they register on the completion edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    arrive     = strat_valid & strat_mask;
    cap_buy_d  = cap_buy_q;
    cap_sell_d = cap_sell_q;
    for (int i = 0; i < NUM_STRAT; i++) begin
      if (arrive[i]) begin
        // A vote carrying both buy and sell counts as neither.
        cap_buy_d[i]  = strat_buy[i] & ~strat_sell[i];
        cap_sell_d[i] = strat_sell[i] & ~strat_buy[i];
      end
    end

    overrun_d   = overrun_q | (|(arrive & got_q));
    window_done = (|strat_mask) && (&(got_q | arrive | ~strat_mask));
    got_d       = window_done ? '0 : (got_q | arrive);

    // NOTE: blocking assignments are correct here: the accumulator is a
    // combinational running sum, each loop iteration builds on the last.
    buy_acc  = '0;
    sell_acc = '0;
    for (int i = 0; i < NUM_STRAT; i++) begin
      if (strat_mask[i] && cap_buy_d[i]) begin
        buy_acc = buy_acc + {{(ACC_W-WEIGHT_W){1'b0}}, buy_weights[i*WEIGHT_W +: WEIGHT_W]};
      end
      if (buy_acc > SCORE_MAX) buy_acc = SCORE_MAX;
      if (strat_mask[i] && cap_sell_d[i]) begin
        sell_acc = sell_acc + {{(ACC_W-WEIGHT_W){1'b0}}, sell_weights[i*WEIGHT_W +: WEIGHT_W]};
      end
      if (sell_acc > SCORE_MAX) sell_acc = SCORE_MAX;
    end

    score_vld_d  = window_done;
    buy_score_d  = window_done ? buy_acc[SCORE_W-1:0]  : buy_score_q;
    sell_score_d = window_done ? sell_acc[SCORE_W-1:0] : sell_score_q;
  end

  // Decision stage and position machine next-state.
  always_comb begin
    raw_buy  = (buy_thresh != '0) && (buy_score_q >= buy_thresh) &&
               (buy_score_q > sell_score_q);
    raw_sell = (sell_thresh != '0) && (sell_score_q >= sell_thresh) &&
               (sell_score_q > buy_score_q);

    pos_d      = pos_q;
    buy_sig_d  = 1'b0;
    sell_sig_d = 1'b0;
    dec_vld_d  = score_vld_q;
    cool_d     = (cool_q != '0) ? cool_q - COOLDOWN_W'(1) : cool_q;

    // While cooling down the decision is still reported but cannot trade.
    if (score_vld_q && (cool_q == '0)) begin
      case (pos_q)
        POS_FLAT: begin
          if (raw_buy) begin
            pos_d     = POS_LONG;
            buy_sig_d = 1'b1;
          end else if (raw_sell) begin
            pos_d      = POS_SHORT;
            sell_sig_d = 1'b1;
          end
        end
        POS_LONG: begin
          if (raw_sell) begin
            sell_sig_d = 1'b1;
`ifdef TLU_FLIP_EN
            pos_d = POS_SHORT;
`else
            pos_d = POS_FLAT;
`endif
          end
        end
        POS_SHORT: begin
          if (raw_buy) begin
            buy_sig_d = 1'b1;
`ifdef TLU_FLIP_EN
            pos_d = POS_LONG;
`else
            pos_d = POS_FLAT;
`endif
          end
        end
        default: pos_d = POS_FLAT;
      endcase
    end

    if (buy_sig_d || sell_sig_d) cool_d = cooldown_cycles;
  end

  // NOTE: the captures are reset along with the control state so a reset
  // mid-window cannot leak stale votes into the next window's scores.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_buy_q    <= '0;
      cap_sell_q   <= '0;
      got_q        <= '0;
      overrun_q    <= 1'b0;
      score_vld_q  <= 1'b0;
      buy_score_q  <= '0;
      sell_score_q <= '0;
      pos_q        <= POS_FLAT;
      cool_q       <= '0;
      dec_vld_q    <= 1'b0;
      buy_sig_q    <= 1'b0;
      sell_sig_q   <= 1'b0;
    end else begin
      cap_buy_q    <= cap_buy_d;
      cap_sell_q   <= cap_sell_d;
      got_q        <= got_d;
      overrun_q    <= overrun_d;
      score_vld_q  <= score_vld_d;
      buy_score_q  <= buy_score_d;
      sell_score_q <= sell_score_d;
      pos_q        <= pos_d;
      cool_q       <= cool_d;
      dec_vld_q    <= dec_vld_d;
      buy_sig_q    <= buy_sig_d;
      sell_sig_q   <= sell_sig_d;
    end
  end

  assign buy_signal     = buy_sig_q;
  assign sell_signal    = sell_sig_q;
  assign position       = pos_q;
  assign decision_valid = dec_vld_q;
  assign buy_score      = buy_score_q;
  assign sell_score     = sell_score_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_tlu_fusion_engine.sv
// -----------------------------------------------------------------------------
// tb_tlu_fusion_engine
//
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (vote arrays, integer sums, position as an int) predicts
// every registered output after each clock edge.
// -----------------------------------------------------------------------------
module tb_tlu_fusion_engine;

  localparam int NS = 3;
  localparam int WW = 4;
  localparam int SW = 8;
  localparam int CW = 8;

`ifdef TLU_FLIP_EN
  localparam int POS_AFTER_LONG_SELL = 2;
`else
  localparam int POS_AFTER_LONG_SELL = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NS-1:0]      strat_valid, strat_buy, strat_sell, strat_mask;
  logic [NS*WW-1:0]   buy_weights, sell_weights;
  logic [SW-1:0]      buy_thresh, sell_thresh;
  logic [CW-1:0]      cooldown_cycles;
  logic               buy_signal, sell_signal, decision_valid, overrun;
  logic [1:0]         position;
  logic [SW-1:0]      buy_score, sell_score;

  int checks   = 0;
  int failures = 0;

  tlu_fusion_engine #(
    .NUM_STRAT(NS), .WEIGHT_W(WW), .SCORE_W(SW), .COOLDOWN_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .strat_valid(strat_valid), .strat_buy(strat_buy), .strat_sell(strat_sell),
    .strat_mask(strat_mask),
    .buy_weights(buy_weights), .sell_weights(sell_weights),
    .buy_thresh(buy_thresh), .sell_thresh(sell_thresh),
    .cooldown_cycles(cooldown_cycles),
    .buy_signal(buy_signal), .sell_signal(sell_signal), .position(position),
    .decision_valid(decision_valid), .buy_score(buy_score), .sell_score(sell_score),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_vote [NS];   // +1 buy, -1 sell, 0 neutral
  bit m_got  [NS];
  bit m_ov, m_svld, m_dv, m_b, m_s;
  int m_bs, m_ss, m_pos, m_cool;

  task automatic model_step();
    int n_pos, n_cool, bsum, ssum, maxs;
    bit n_b, n_s, rb, rs, done;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin m_vote[i] = 0; m_got[i] = 0; end
      m_ov = 0; m_svld = 0; m_dv = 0; m_b = 0; m_s = 0;
      m_bs = 0; m_ss = 0; m_pos = 0; m_cool = 0;
      return;
    end
    // decision on the scores currently visible
    n_b = 0; n_s = 0; n_pos = m_pos;
    n_cool = (m_cool > 0) ? m_cool - 1 : 0;
    if (m_svld && m_cool == 0) begin
      rb = (buy_thresh != 0) && (m_bs >= int'(buy_thresh)) && (m_bs > m_ss);
      rs = (sell_thresh != 0) && (m_ss >= int'(sell_thresh)) && (m_ss > m_bs);
      if (rb && m_pos != 1) begin
        n_b = 1;
`ifdef TLU_FLIP_EN
        n_pos = 1;
`else
        n_pos = (m_pos == 0) ? 1 : 0;
`endif
      end else if (rs && m_pos != 2) begin
        n_s = 1;
`ifdef TLU_FLIP_EN
        n_pos = 2;
`else
        n_pos = (m_pos == 0) ? 2 : 0;
`endif
      end
      if (n_b || n_s) n_cool = int'(cooldown_cycles);
    end
    m_dv = m_svld; m_b = n_b; m_s = n_s; m_pos = n_pos; m_cool = n_cool;
    // collection
    for (int i = 0; i < NS; i++) begin
      if (strat_valid[i] && strat_mask[i]) begin
        if (m_got[i]) m_ov = 1;
        m_got[i]  = 1;
        m_vote[i] = (strat_buy[i] && !strat_sell[i]) ? 1 :
                    (strat_sell[i] && !strat_buy[i]) ? -1 : 0;
      end
    end
    done = (strat_mask != 0);
    for (int i = 0; i < NS; i++) if (strat_mask[i] && !m_got[i]) done = 0;
    m_svld = done;
    if (done) begin
      bsum = 0; ssum = 0; maxs = (1 << SW) - 1;
      for (int i = 0; i < NS; i++) begin
        if (strat_mask[i] && m_vote[i] == 1)  bsum += int'(buy_weights[i*WW +: WW]);
        if (strat_mask[i] && m_vote[i] == -1) ssum += int'(sell_weights[i*WW +: WW]);
      end
      m_bs = (bsum > maxs) ? maxs : bsum;
      m_ss = (ssum > maxs) ? maxs : ssum;
      for (int i = 0; i < NS; i++) m_got[i] = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("decision_valid", 32'(decision_valid), 32'(m_dv));
    chk("buy_signal",     32'(buy_signal),     32'(m_b));
    chk("sell_signal",    32'(sell_signal),    32'(m_s));
    chk("position",       32'(position),       32'(m_pos));
    chk("buy_score",      32'(buy_score),      32'(m_bs));
    chk("sell_score",     32'(sell_score),     32'(m_ss));
    chk("overrun",        32'(overrun),        32'(m_ov));
  endtask

  // Apply one cycle of votes, advance the model and the DUT, then compare.
  task automatic tick(input logic [NS-1:0] v, input logic [NS-1:0] b, input logic [NS-1:0] s);
    strat_valid = v; strat_buy = b; strat_sell = s;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    tick(3'b000, 3'b000, 3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    strat_valid = '0; strat_buy = '0; strat_sell = '0; strat_mask = 3'b111;
    buy_weights  = {4'd2, 4'd1, 4'd4};
    sell_weights = {4'd1, 4'd1, 4'd1};
    buy_thresh = 8'd2; sell_thresh = 8'd2; cooldown_cycles = 8'd0;

    // Reset state
    idle(); idle();
    rst = 1'b0;
    chk("reset_position", 32'(position), 0);
    chk("reset_dv",       32'(decision_valid), 0);
    chk("reset_overrun",  32'(overrun), 0);

    // Staggered arrivals: strat0 buy, strat1/strat2 neutral later
    tick(3'b001, 3'b001, 3'b000);
    tick(3'b010, 3'b000, 3'b000);
    idle();
    tick(3'b100, 3'b000, 3'b000);
    chk("t1_buy_score", 32'(buy_score), 4);
    idle();
    chk("t1_dv", 32'(decision_valid), 1);
    chk("t1_buy_signal", 32'(buy_signal), 1);
    chk("t1_position_long", 32'(position), 1);
    idle();
    chk("t1_buy_pulse_end", 32'(buy_signal), 0);

    // From LONG, all three vote sell together
    tick(3'b111, 3'b000, 3'b111);
    chk("t2_sell_score", 32'(sell_score), 3);
    idle();
    chk("t2_sell_signal", 32'(sell_signal), 1);
    chk("t2_no_buy", 32'(buy_signal), 0);
    chk("t2_position", 32'(position), POS_AFTER_LONG_SELL);

    // Cooldown suppression
    do_reset();
    cooldown_cycles = 8'd5;
    tick(3'b111, 3'b001, 3'b000);
    idle();
    chk("t3_buy_signal", 32'(buy_signal), 1);
    tick(3'b111, 3'b000, 3'b111);
    idle();
    chk("t3_cool_dv", 32'(decision_valid), 1);
    chk("t3_cool_no_sell", 32'(sell_signal), 0);
    chk("t3_cool_hold_long", 32'(position), 1);
    idle(); idle();
    tick(3'b111, 3'b000, 3'b111);
    idle();
    chk("t3_after_cool_sell", 32'(sell_signal), 1);
    chk("t3_after_cool_pos", 32'(position), POS_AFTER_LONG_SELL);

    // Overrun: strat0 reports twice in one window, second vote wins
    do_reset();
    cooldown_cycles = 8'd0;
    tick(3'b001, 3'b001, 3'b000);
    tick(3'b001, 3'b000, 3'b001);
    chk("t4_overrun_set", 32'(overrun), 1);
    tick(3'b110, 3'b000, 3'b000);
    chk("t4_second_vote_sell", 32'(sell_score), 1);
    chk("t4_second_vote_buy",  32'(buy_score), 0);
    idle();
    chk("t4_dv", 32'(decision_valid), 1);
    chk("t4_overrun_sticky", 32'(overrun), 1);

    // Mask 101: strat1 ignored
    strat_mask = 3'b101;
    tick(3'b010, 3'b010, 3'b000);
    tick(3'b101, 3'b101, 3'b000);
    chk("t5_masked_score", 32'(buy_score), 6);
    idle();
    chk("t5_masked_buy", 32'(buy_signal), 1);
    // Mask 000: never completes
    strat_mask = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick(3'b111, 3'b111, 3'b000);
      chk("t5_mask0_no_dv", 32'(decision_valid), 0);
    end

    // Equal scores -> no trade
    do_reset();
    strat_mask   = 3'b111;
    buy_weights  = {4'd0, 4'd1, 4'd2};
    sell_weights = {4'd3, 4'd1, 4'd1};
    tick(3'b111, 3'b011, 3'b100);
    chk("t6_eq_buy", 32'(buy_score), 3);
    chk("t6_eq_sell", 32'(sell_score), 3);
    idle();
    chk("t6_eq_dv", 32'(decision_valid), 1);
    chk("t6_eq_no_buy", 32'(buy_signal), 0);
    chk("t6_eq_no_sell", 32'(sell_signal), 0);
    // Both-vote from strat1 counts as neither
    tick(3'b111, 3'b011, 3'b010);
    chk("t6_both_vote", 32'(buy_score), 2);
    idle();
    chk("t6_both_buy", 32'(buy_signal), 1);
    // Reset mid-window discards partial captures
    tick(3'b001, 3'b001, 3'b000);
    do_reset();
    chk("t6_rst_pos", 32'(position), 0);
    chk("t6_rst_score", 32'(buy_score), 0);
    tick(3'b110, 3'b000, 3'b000);
    idle();
    chk("t6_rst_no_dv", 32'(decision_valid), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        buy_weights     = NS*WW'($urandom);
        sell_weights    = NS*WW'($urandom);
        buy_thresh      = SW'($urandom_range(0, 14));
        sell_thresh     = SW'($urandom_range(0, 14));
        cooldown_cycles = CW'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 19) == 0) strat_mask = NS'($urandom);
      else if ($urandom_range(0, 9) == 0) strat_mask = 3'b111;
      rst = ($urandom_range(0, 149) == 0);
      tick(NS'($urandom & $urandom), NS'($urandom), NS'($urandom));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlu_fusion_engine.md
Name: tlu_fusion_engine

Overview:
Parametrised successor to the fixed three-strategy trade logic unit. It collects buy/sell votes from NUM_STRAT strategy channels whose valids arrive on different cycles, then forms runtime-weighted buy and sell scores. Scores are compared against runtime thresholds. A position state machine (FLAT/LONG/SHORT) with a post-trade cooldown produces single-cycle buy/sell pulses. It sits between the strategy modules and the order-entry path.

Parameters:
NUM_STRAT, 3, number of strategy input channels (1..16).
WEIGHT_W, 4, width of each per-strategy weight.
SCORE_W, 8, score accumulator width; must be >= WEIGHT_W + clog2(NUM_STRAT).
COOLDOWN_W, 8, cooldown counter width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
strat_valid  in  NUM_STRAT  per-strategy result valid (1-cycle pulse).
strat_buy  in  NUM_STRAT  per-strategy buy vote, qualified by strat_valid.
strat_sell  in  NUM_STRAT  per-strategy sell vote, qualified by strat_valid.
strat_mask  in  NUM_STRAT  1 = strategy participates.
buy_weights  in  NUM_STRAT*WEIGHT_W  buy weight; strategy i occupies bits [i*WEIGHT_W +: WEIGHT_W].
sell_weights  in  NUM_STRAT*WEIGHT_W  sell weight; same packing.
buy_thresh  in  SCORE_W  buy score threshold; 0 = buy side disabled.
sell_thresh  in  SCORE_W  sell score threshold; 0 = sell side disabled.
cooldown_cycles  in  COOLDOWN_W  cycles to suppress trading after a position change.
buy_signal  out  1  1-cycle buy pulse.
sell_signal  out  1  1-cycle sell pulse.
position  out  2  00 FLAT, 01 LONG, 10 SHORT.
decision_valid  out  1  1-cycle pulse for each evaluated sample.
buy_score  out  SCORE_W  last registered buy score.
sell_score  out  SCORE_W  last registered sell score.
overrun  out  1  sticky; set when a strategy delivers twice in one collection window.

Behaviour:
- Reset: all outputs 0, position FLAT, capture/got registers cleared, cooldown counter 0.
- Collect:
  - On strat_valid[i] && strat_mask[i], latch the buy/sell vote into capture[i] and set got[i].
  - If got[i] is already set when a new valid arrives, overwrite capture[i] and set overrun. overrun clears only on rst.
  - A vote with both buy and sell asserted counts as neither.
- Completion: evaluated every cycle as &(got | ~strat_mask) with strat_mask != 0, using the current cycle's arrivals.
  - Masked-out strategies contribute nothing, even if previously captured.
  - strat_mask == 0 never completes.
- Score stage (cycle after completion):
  - buy_score = sum of buy_weights[i] for captured buys; sell_score likewise for sells.
  - Weights are zero-extended; sums saturate at 2^SCORE_W-1.
  - got is cleared the same cycle. A valid arriving in that same cycle is kept and belongs to the next window.
- Decision stage (cycle after score):
  - raw_buy = buy_thresh != 0 && buy_score >= buy_thresh && buy_score > sell_score.
  - raw_sell = sell_thresh != 0 && sell_score >= sell_thresh && sell_score > buy_score.
  - Equal scores produce no trade.
  - decision_valid pulses every evaluation, trade or not.
- FSM (only when cooldown counter == 0):
  - FLAT + raw_buy -> LONG, buy_signal pulse.
  - FLAT + raw_sell -> SHORT, sell_signal pulse.
  - LONG + raw_sell -> FLAT, sell_signal pulse.
  - SHORT + raw_buy -> FLAT, buy_signal pulse.
  - LONG + raw_buy and SHORT + raw_sell: hold, no pulse (no pyramiding).
- Cooldown:
  - Every position change loads the counter with cooldown_cycles. The counter decrements each clock down to 0.
  - Decisions made while it is nonzero are suppressed: decision_valid still pulses, and no trade or FSM change occurs.
- Latency: last required strat_valid at cycle T -> scores registered at T+1 -> decision_valid and any buy/sell at T+2.
- Throughput: one decision per completed window; windows may complete on consecutive cycles.
- buy_signal and sell_signal are never asserted together.
- rst mid-window discards all partial captures.

Optional Feature:
TLU_FLIP_EN: when defined, LONG + raw_sell -> SHORT and SHORT + raw_buy -> LONG directly (single pulse, cooldown loaded). When undefined, those events go to FLAT as above.

Test Plan:
- NUM_STRAT=3, mask=111, buy_weights={2,1,4} (strat2..0), buy_thresh=2, sell_thresh=2, cooldown 0; strat0 buy at T, strat1 neutral at T+1, strat2 neutral at T+3 -> buy_score=4, buy_signal and decision_valid at T+5, position=LONG.
- From LONG, all three vote sell simultaneously with sell_weights all 1 -> sell_score=3, sell_signal 2 cycles later, position=FLAT (TLU_FLIP_EN undefined) or SHORT (defined).
- cooldown_cycles=5; buy trade then an immediate sell window completing 2 cycles later -> decision_valid=1, no sell_signal, position unchanged; same window after 6 cycles -> sell fires.
- strat0 valid twice before strat1/strat2 arrive -> overrun=1 and stays 1; score uses the second vote.
- mask=101, strat1 never valid -> window completes on strat0+strat2; strat1 buy ignored; mask=000 -> no decision_valid ever.
- buy_score=sell_score=3, thresholds 2 -> decision_valid=1, no trade; rst asserted mid-window -> no decision, all outputs 0.
